// File: rtl/chip8_audio_pkg.sv
// chip8_audio_pkg: gate-state encodings, reset constants and the XO-CHIP pitch increment helper.
package chip8_audio_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, HELD} gate_t;
  localparam logic [7:0] PITCH_DEFAULT = 8'd64;
  localparam logic [127:0] PATTERN_RESET = {8{8'hFF, 8'h00}};
  // BASE_INC[k] entry, rounded to nearest; evaluated only at elaboration
  function automatic longint base_inc(int k, int clk_hz, int acc_w);
    return longint'(4000.0 * 2.0 ** ((k - 64) / 48.0) * 2.0 ** acc_w / clk_hz);
  endfunction
endpackage

// File: rtl/chip8_pattern_player.sv
// chip8_pattern_player: XO-CHIP 16x8 pattern RAM, pitch register and phase accumulator driving the sample bit.
module chip8_pattern_player
  import chip8_audio_pkg::*;
#(
  parameter int CLK_HZ = 4857480,
  parameter int ACC_W  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       gate,
  input  logic       pat_we,
  input  logic [3:0] pat_addr,
  input  logic [7:0] pat_din,
  input  logic       pitch_we,
  input  logic [7:0] pitch_din,
  output logic       wave
);
  localparam int IW = ACC_W + 6;
  logic [7:0] pat [16];
  logic [7:0] pitch;
  logic [ACC_W-1:0] phase;
  logic [6:0] bit_idx;
  logic [IW-1:0] tbl [48];
  logic [IW-1:0] inc, sum;
  logic [5:0] k_idx;
  logic [2:0] oct;
  logic carry;
  for (genvar k = 0; k < 48; k++) begin : g_tbl
    localparam logic [IW-1:0] V = IW'(base_inc(k, CLK_HZ, ACC_W));
    assign tbl[k] = V;
  end
  assign k_idx = 6'(pitch % 8'd48);
  assign oct = 3'(pitch / 8'd48);
  assign inc = tbl[k_idx] << oct;
  assign sum = IW'(phase) + inc;
  assign carry = |sum[IW-1:ACC_W];
  assign wave = pat[bit_idx[6:3]][~bit_idx[2:0]];
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < 16; i++) pat[i] <= PATTERN_RESET[127-8*i -: 8];
      pitch <= PITCH_DEFAULT;
      phase <= '0;
      bit_idx <= '0;
    end else begin
      if (pat_we) pat[pat_addr] <= pat_din;
      if (pitch_we) pitch <= pitch_din;
      if (start) begin
        phase <= '0;
        bit_idx <= '0;
      end else if (gate) begin
        phase <= sum[ACC_W-1:0];
        bit_idx <= bit_idx + 7'(carry);
      end
    end
endmodule

// File: rtl/chip8_beeper.sv
// chip8_beeper: gated speaker driver with one-frame minimum note; XO_AUDIO_EN selects the pattern player over the square tone.
module chip8_beeper
  import chip8_audio_pkg::*;
#(
  parameter int CLK_HZ  = 4857480,
  parameter int TONE_HZ = 440,
  parameter int ACC_W   = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       beep,
  input  logic       pat_we,
  input  logic [3:0] pat_addr,
  input  logic [7:0] pat_din,
  input  logic       pitch_we,
  input  logic [7:0] pitch_din,
  output logic       spkr
);
  gate_t state;
  logic beep_q, vsync_q, start, tick, gate, wave;
  assign start = beep & ~beep_q;
  assign tick = vsync & ~vsync_q;
  assign gate = state != IDLE;
  // start outranks a coincident tick, so a fresh note always waits for a full frame
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      beep_q <= 1'b0;
      vsync_q <= 1'b0;
      spkr <= 1'b0;
    end else begin
      beep_q <= beep;
      vsync_q <= vsync;
      spkr <= gate & wave;
      state <= start ? ARMED : (state == ARMED && tick) ? HELD : (state == HELD && !beep) ? IDLE : state;
    end
`ifdef XO_AUDIO_EN
  chip8_pattern_player #(.CLK_HZ(CLK_HZ), .ACC_W(ACC_W)) u_player (
    .clk(clk), .reset(reset), .start(start), .gate(gate),
    .pat_we(pat_we), .pat_addr(pat_addr), .pat_din(pat_din),
    .pitch_we(pitch_we), .pitch_din(pitch_din), .wave(wave)
  );
  logic unused_ok;
  assign unused_ok = TONE_HZ[0];
`else
  localparam int HALF = CLK_HZ / (2 * TONE_HZ) > 1 ? CLK_HZ / (2 * TONE_HZ) : 1;
  localparam int DW = HALF > 1 ? $clog2(HALF) : 1;
  logic [DW-1:0] divider;
  logic sq;
  always_ff @(posedge clk)
    if (reset) begin
      divider <= '0;
      sq <= 1'b1;
    end else if (start) begin
      divider <= '0;
      sq <= 1'b1;
    end else if (gate) begin
      divider <= divider == DW'(HALF - 1) ? '0 : divider + 1'b1;
      sq <= divider == DW'(HALF - 1) ? ~sq : sq;
    end
  assign wave = sq;
  logic unused_ok;
  assign unused_ok = ^{pat_we, pat_addr, pat_din, pitch_we, pitch_din, ACC_W[0]};
`endif
endmodule

// File: tb/tb_chip8_beeper.sv
// tb_chip8_beeper: randomized and directed stimulus checked every cycle against a note-level model (XO_AUDIO_EN aware).
module tb_chip8_beeper;
  logic clk = 1'b0, reset = 1'b1, vsync = 1'b0, beep = 1'b0;
  logic pat_we = 1'b0, pitch_we = 1'b0;
  logic [3:0] pat_addr = '0;
  logic [7:0] pat_din = '0, pitch_din = '0;
  logic spkr;
  int errors = 0, checks = 0;
  bit chk_en = 1'b0;

  chip8_beeper #(.CLK_HZ(8000), .TONE_HZ(1000), .ACC_W(32)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .beep(beep),
    .pat_we(pat_we), .pat_addr(pat_addr), .pat_din(pat_din),
    .pitch_we(pitch_we), .pitch_din(pitch_din), .spkr(spkr)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: spkr=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a note is active from a beep rise until beep is low after the first frame tick.
  bit m_active, m_armed, m_beep_q, m_vs_q, exp_spkr;
  int m_n;
  longint m_acc;
  logic [7:0] m_pat [16];
  int m_pitch;

  function automatic longint exp_inc(int p);
    return longint'(4000.0 * 2.0 ** ((p % 48 - 64) / 48.0) * 2.0 ** 32 / 8000.0) << (p / 48);
  endfunction

  function automatic bit wave_now();
`ifdef XO_AUDIO_EN
    int idx;
    idx = int'((m_acc >> 32) % 128);
    return m_pat[idx / 8][7 - idx % 8];
`else
    return ((m_n / 4) % 2) == 0;
`endif
  endfunction

  always @(posedge clk) begin
    bit st, tk;
    st = beep && !m_beep_q;
    tk = vsync && !m_vs_q;
    if (reset) begin
      exp_spkr = 1'b0;
      m_active = 1'b0;
      m_armed = 1'b0;
      m_n = 0;
      m_acc = 0;
      m_pitch = 64;
      for (int i = 0; i < 16; i++) m_pat[i] = (i % 2 == 1) ? 8'h00 : 8'hFF;
      m_beep_q = 1'b0;
      m_vs_q = 1'b0;
    end else begin
      exp_spkr = m_active && wave_now();
      if (st) begin
        m_active = 1'b1;
        m_armed = 1'b1;
        m_n = 0;
        m_acc = 0;
      end else if (m_active) begin
        m_n++;
        m_acc += exp_inc(m_pitch);
        if (m_armed && tk) m_armed = 1'b0;
        else if (!m_armed && !beep) m_active = 1'b0;
      end
      if (pat_we) m_pat[pat_addr] = pat_din;
      if (pitch_we) m_pitch = int'(pitch_din);
      m_beep_q = beep;
      m_vs_q = vsync;
    end
  end

  always @(negedge clk) if (chk_en) check("spkr_vs_model", spkr, exp_spkr);

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_seq(string name, logic [15:0] bits, int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      check(name, spkr, bits[len-1-i]);
    end
  endtask

  task automatic quiet();
    beep = 1'b0;
    vsync = 1'b1;
    step(2);
    vsync = 1'b0;
    step(5);
  endtask

  task automatic wr_pat(int a, logic [7:0] d);
    pat_we = 1'b1;
    pat_addr = 4'(a);
    pat_din = d;
    step(1);
    pat_we = 1'b0;
  endtask

  task automatic wr_pitch(logic [7:0] p);
    pitch_we = 1'b1;
    pitch_din = p;
    step(1);
    pitch_we = 1'b0;
  endtask

  initial begin
    step(1);
    chk_en = 1'b1;
    step(2);
    check("reset_spkr", spkr, 1'b0);
    reset = 1'b0;
    step(3);
    check("idle_spkr", spkr, 1'b0);
    // directed tone start: first high one cycle after gate rises
    beep = 1'b1;
`ifdef XO_AUDIO_EN
    expect_seq("xo_default_start", 16'b0111111111111111, 16);
`else
    expect_seq("square_start", 16'b0111100001111000, 16);
`endif
    step(20);
    quiet();
    check("after_quiet", spkr, 1'b0);
    // minimum length: short beep lasts until the next frame tick
    beep = 1'b1;
    step(3);
    beep = 1'b0;
    step(500);
    vsync = 1'b1;
    step(3);
    check("min_len_end", spkr, 1'b0);
    vsync = 1'b0;
    step(10);
    check("min_len_held0", spkr, 1'b0);
    // retrigger while armed restarts the waveform
    beep = 1'b1;
    step(2);
    beep = 1'b0;
    step(1);
    beep = 1'b1;
`ifdef XO_AUDIO_EN
    step(10);
`else
    expect_seq("retrigger", 16'b1111100001, 10);
`endif
    // reset mid-note
    reset = 1'b1;
    beep = 1'b0;
    step(1);
    check("reset_mid_note", spkr, 1'b0);
    reset = 1'b0;
    step(20);
    check("no_sound_after_reset", spkr, 1'b0);
    // pattern and pitch programming (ignored by the square build)
    for (int i = 0; i < 16; i++) wr_pat(i, i == 0 ? 8'hA0 : 8'h00);
    wr_pitch(8'd64);
    beep = 1'b1;
`ifdef XO_AUDIO_EN
    expect_seq("xo_pattern", 16'b0110011000000000, 16);
`else
    step(16);
`endif
    quiet();
    wr_pitch(8'd112);
    beep = 1'b1;
`ifdef XO_AUDIO_EN
    expect_seq("xo_pitch112", 16'b0101000000, 10);
`else
    step(10);
`endif
    step(7);
    wr_pitch(8'd64);
    step(40);
    wr_pitch(8'd100);
    step(40);
    quiet();
    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(39) == 0) beep = ~beep;
      vsync = (c % 97) < 3;
      pat_we = $urandom_range(7) == 0;
      pat_addr = 4'($urandom_range(15));
      pat_din = 8'($urandom);
      pitch_we = $urandom_range(49) == 0;
      pitch_din = 8'($urandom_range(112, 30));
      reset = (c == 2000);
      if (reset) beep = 1'b0;
      step(1);
    end
    reset = 1'b0;
    pat_we = 1'b0;
    pitch_we = 1'b0;
    quiet();
    check("final_quiet", spkr, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
